// File: rtl/if_stage_param.sv
// Instruction-fetch stage: writable instruction memory, PC redirect/stall,
// and the IF/ID pipeline register feeding decode.
module if_stage_param #(
    parameter int                   INSTR_W  = 32,
    parameter int                   PC_W     = 32,
    parameter int                   DEPTH    = 64,
    parameter logic [INSTR_W-1:0]   NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               imem_we,
    input  logic [PC_W-1:0]    imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc_next,
    output logic               if_id_valid,
    output logic               if_id_oob
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2^PC_W is still representable in the range test.
    localparam logic [PC_W:0] DEPTH_X = (PC_W + 1)'(DEPTH);

    logic [INSTR_W-1:0] r_imem [DEPTH];

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_next;
    logic               r_valid;
    logic               r_oob;

    logic [PC_W-1:0]    w_pc_inc;
    logic               w_fetch_oob;
    logic               w_wr_ok;
    logic [AW-1:0]      w_rd_idx;
    logic [AW-1:0]      w_wr_idx;
    logic [INSTR_W-1:0] w_fetch_instr;

    assign w_pc_inc      = r_pc + PC_W'(1);
    assign w_fetch_oob   = ({1'b0, r_pc} >= DEPTH_X);
    assign w_wr_ok       = imem_we && ({1'b0, imem_waddr} < DEPTH_X);
    assign w_rd_idx      = r_pc[AW-1:0];
    assign w_wr_idx      = imem_waddr[AW-1:0];
    assign w_fetch_instr = w_fetch_oob ? NOP_WORD : r_imem[w_rd_idx];

    // Memory is never cleared; the asynchronous read above sees the old word on a same-cycle write.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_imem[w_wr_idx] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= '0;
            r_instr   <= NOP_WORD;
            r_pc_next <= '0;
            r_valid   <= 1'b0;
            r_oob     <= 1'b0;
        end else if (branch_taken) begin
            r_pc      <= branch_target;
            r_instr   <= NOP_WORD;
            r_pc_next <= '0;
            r_valid   <= 1'b0;
            r_oob     <= 1'b0;
        end else if (!freeze) begin
            r_pc      <= w_pc_inc;
            r_instr   <= w_fetch_instr;
            r_pc_next <= w_pc_inc;
            r_valid   <= 1'b1;
            r_oob     <= w_fetch_oob;
        end
    end

    assign pc            = r_pc;
    assign if_id_instr   = r_instr;
    assign if_id_pc_next = r_pc_next;
    assign if_id_valid   = r_valid;
    assign if_id_oob     = r_oob;

endmodule
